// File: rtl/white_locator_pkg.sv
// Shared types and constants for the white-pixel locator: result record,
// FSM encoding and the fixed centroid accumulator width.
package white_locator_pkg;

   localparam logic [15:0] WHITE_PIXEL = 16'hFFFF;
   localparam int unsigned SUM_W       = 28;

   // Record fields are sized for the full 640x480 raster; smaller rasters use the low bits.
   localparam int unsigned RES_X_W   = 10;
   localparam int unsigned RES_Y_W   = 9;
   localparam int unsigned RES_CNT_W = 19;

   typedef enum logic [1:0] {IDLE, DIVIDE, HOLD} state_t;

   typedef struct packed {
      logic                 found;
      logic [RES_CNT_W-1:0] count;
      logic [RES_X_W-1:0]   x_min;
      logic [RES_X_W-1:0]   x_max;
      logic [RES_Y_W-1:0]   y_min;
      logic [RES_Y_W-1:0]   y_max;
      logic [RES_X_W-1:0]   x_cen;
      logic [RES_Y_W-1:0]   y_cen;
   } result_t;

endpackage

// File: rtl/white_locator_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// produced on the start edge, so done pulses DIVIDEND_W-1 cycles after start.
module seq_divider
   import white_locator_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = SUM_W,
   parameter int unsigned DIVISOR_W  = 19,
   parameter int unsigned QUOT_W     = DIVIDEND_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  done,
   output logic [QUOT_W-1:0]     quotient
);

   localparam int unsigned STEP_W = $clog2(DIVIDEND_W + 1);

   logic [DIVISOR_W-1:0]  rem, src_rem, next_rem;
   logic [DIVIDEND_W-1:0] quo, src_quo, next_quo;
   logic [DIVISOR_W:0]    shifted, diff;
   logic [STEP_W-1:0]     steps;
   logic                  ge;

   // Partial remainder stays below the divisor, so a clear sign bit means "fits".
   always_comb begin
      src_rem  = start ? '0 : rem;
      src_quo  = start ? dividend : quo;
      shifted  = {src_rem, src_quo[DIVIDEND_W-1]};
      diff     = shifted - {1'b0, divisor};
      ge       = ~diff[DIVISOR_W];
      next_rem = ge ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
      next_quo = {src_quo[DIVIDEND_W-2:0], ge};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem   <= '0;
         quo   <= '0;
         steps <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem   <= next_rem;
            quo   <= next_quo;
            steps <= STEP_W'(DIVIDEND_W - 1);
         end else if (steps != '0) begin
            rem   <= next_rem;
            quo   <= next_quo;
            steps <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) done <= 1'b1;
         end
      end
   end

   assign quotient = quo[QUOT_W-1:0];

endmodule

// File: rtl/white_locator.sv
// Reduces each frame of the white mask to count, bounding box and centroid,
// delivered as one record per frame over valid/ready.
module white_locator
   import white_locator_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned MIN_COUNT = 4,
   parameter int unsigned X_W       = $clog2(H_ACTIVE),
   parameter int unsigned Y_W       = $clog2(V_ACTIVE),
   parameter int unsigned CNT_W     = $clog2(H_ACTIVE * V_ACTIVE + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_valid,
   input  logic             frame_start,
   input  logic [15:0]      mask,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             found,
   output logic [CNT_W-1:0] count,
   output logic [X_W-1:0]   x_min,
   output logic [X_W-1:0]   x_max,
   output logic [Y_W-1:0]   y_min,
   output logic [Y_W-1:0]   y_max,
   output logic [X_W-1:0]   x_cen,
   output logic [Y_W-1:0]   y_cen,
   output logic             overrun
);

   logic [X_W-1:0]   last_x, cur_x, acc_xmin, acc_xmax, base_xmin, base_xmax, nxt_xmin, nxt_xmax;
   logic [Y_W-1:0]   last_y, cur_y, acc_ymin, acc_ymax, base_ymin, base_ymax, nxt_ymin, nxt_ymax;
   logic [CNT_W-1:0] acc_cnt, base_cnt, nxt_cnt;
   logic [SUM_W-1:0] acc_sx, acc_sy, base_sx, base_sy, nxt_sx, nxt_sy;
   logic             in_frame, active, frame_end;

   logic [X_W-1:0]   snap_xmin, snap_xmax;
   logic [Y_W-1:0]   snap_ymin, snap_ymax;
   logic [CNT_W-1:0] snap_cnt;
   logic [SUM_W-1:0] snap_sx, snap_sy;
   logic             snap_valid;

   state_t           state;
   result_t          result;
   logic             div_start, done_x, done_y;
   logic [X_W-1:0]   quo_x;
   logic [Y_W-1:0]   quo_y;

   // A frame_start pixel sees freshly cleared accumulators, discarding any partial frame.
   always_comb begin
      cur_x = '0;
      cur_y = '0;
      if (!frame_start) begin
         if (last_x == X_W'(H_ACTIVE - 1)) begin
            cur_y = last_y + Y_W'(1);
         end else begin
            cur_x = last_x + X_W'(1);
            cur_y = last_y;
         end
      end
      active    = pix_valid && (frame_start || in_frame);
      frame_end = active && (cur_x == X_W'(H_ACTIVE - 1)) && (cur_y == Y_W'(V_ACTIVE - 1));

      base_cnt  = frame_start ? '0 : acc_cnt;
      base_sx   = frame_start ? '0 : acc_sx;
      base_sy   = frame_start ? '0 : acc_sy;
      base_xmin = frame_start ? '1 : acc_xmin;
      base_xmax = frame_start ? '0 : acc_xmax;
      base_ymin = frame_start ? '1 : acc_ymin;
      base_ymax = frame_start ? '0 : acc_ymax;

      nxt_cnt  = base_cnt;
      nxt_sx   = base_sx;
      nxt_sy   = base_sy;
      nxt_xmin = base_xmin;
      nxt_xmax = base_xmax;
      nxt_ymin = base_ymin;
      nxt_ymax = base_ymax;
      if (mask == WHITE_PIXEL) begin
         nxt_cnt = base_cnt + CNT_W'(1);
         nxt_sx  = base_sx + SUM_W'(cur_x);
         nxt_sy  = base_sy + SUM_W'(cur_y);
         if (cur_x < base_xmin) nxt_xmin = cur_x;
         if (cur_x > base_xmax) nxt_xmax = cur_x;
         if (cur_y < base_ymin) nxt_ymin = cur_y;
         if (cur_y > base_ymax) nxt_ymax = cur_y;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_x     <= '0;
         last_y     <= '0;
         in_frame   <= 1'b0;
         acc_cnt    <= '0;
         acc_sx     <= '0;
         acc_sy     <= '0;
         acc_xmin   <= '1;
         acc_xmax   <= '0;
         acc_ymin   <= '1;
         acc_ymax   <= '0;
         snap_valid <= 1'b0;
         snap_cnt   <= '0;
         snap_sx    <= '0;
         snap_sy    <= '0;
         snap_xmin  <= '0;
         snap_xmax  <= '0;
         snap_ymin  <= '0;
         snap_ymax  <= '0;
      end else begin
         snap_valid <= 1'b0;
         if (active) begin
            last_x <= cur_x;
            last_y <= cur_y;
            if (frame_end) begin
               snap_valid <= 1'b1;
               snap_cnt   <= nxt_cnt;
               snap_sx    <= nxt_sx;
               snap_sy    <= nxt_sy;
               snap_xmin  <= nxt_xmin;
               snap_xmax  <= nxt_xmax;
               snap_ymin  <= nxt_ymin;
               snap_ymax  <= nxt_ymax;
               in_frame   <= 1'b0;
               acc_cnt    <= '0;
               acc_sx     <= '0;
               acc_sy     <= '0;
               acc_xmin   <= '1;
               acc_xmax   <= '0;
               acc_ymin   <= '1;
               acc_ymax   <= '0;
            end else begin
               in_frame <= 1'b1;
               acc_cnt  <= nxt_cnt;
               acc_sx   <= nxt_sx;
               acc_sy   <= nxt_sy;
               acc_xmin <= nxt_xmin;
               acc_xmax <= nxt_xmax;
               acc_ymin <= nxt_ymin;
               acc_ymax <= nxt_ymax;
            end
         end
      end
   end

   assign div_start = (state == IDLE) && snap_valid && (snap_cnt != '0);

   seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W), .QUOT_W(X_W)) u_div_x (
      .clk(clk), .reset(reset), .start(div_start), .dividend(snap_sx),
      .divisor(snap_cnt), .done(done_x), .quotient(quo_x)
   );

   seq_divider #(.DIVIDEND_W(SUM_W), .DIVISOR_W(CNT_W), .QUOT_W(Y_W)) u_div_y (
      .clk(clk), .reset(reset), .start(div_start), .dividend(snap_sy),
      .divisor(snap_cnt), .done(done_y), .quotient(quo_y)
   );

   // Count and box are loaded on entry to DIVIDE; res_valid is still low then.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         result    <= '0;
         res_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (snap_valid && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (snap_valid) begin
                  if (snap_cnt != '0) begin
                     state        <= DIVIDE;
                     result.found <= (snap_cnt >= CNT_W'(MIN_COUNT));
                     result.count <= RES_CNT_W'(snap_cnt);
                     result.x_min <= RES_X_W'(snap_xmin);
                     result.x_max <= RES_X_W'(snap_xmax);
                     result.y_min <= RES_Y_W'(snap_ymin);
                     result.y_max <= RES_Y_W'(snap_ymax);
                     result.x_cen <= '0;
                     result.y_cen <= '0;
                  end else begin
                     state     <= HOLD;
                     result    <= '0;
                     res_valid <= 1'b1;
                  end
               end
            end
            DIVIDE: begin
               if (done_x && done_y) begin
                  state        <= HOLD;
                  res_valid    <= 1'b1;
                  result.x_cen <= RES_X_W'(quo_x);
                  result.y_cen <= RES_Y_W'(quo_y);
               end
            end
            HOLD: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign found = result.found;
   assign count = result.count[CNT_W-1:0];
   assign x_min = result.x_min[X_W-1:0];
   assign x_max = result.x_max[X_W-1:0];
   assign y_min = result.y_min[Y_W-1:0];
   assign y_max = result.y_max[Y_W-1:0];
   assign x_cen = result.x_cen[X_W-1:0];
   assign y_cen = result.y_cen[Y_W-1:0];

endmodule

// File: tb/tb_white_locator.sv
// Scoreboard bench for white_locator on a reduced 40x30 raster; test-plan
// coordinates are scaled into that raster.
module tb_white_locator;

   localparam int unsigned H       = 40;
   localparam int unsigned V       = 30;
   localparam int unsigned XW      = $clog2(H);
   localparam int unsigned YW      = $clog2(V);
   localparam int unsigned CW      = $clog2(H * V + 1);
   localparam int unsigned LAT_DIV = 30;
   localparam int unsigned LAT_ZERO = 2;

   typedef struct packed {
      logic          found;
      logic [CW-1:0] count;
      logic [XW-1:0] x_min;
      logic [XW-1:0] x_max;
      logic [YW-1:0] y_min;
      logic [YW-1:0] y_max;
      logic [XW-1:0] x_cen;
      logic [YW-1:0] y_cen;
   } rec_t;

   typedef struct {
      rec_t        rec;
      int unsigned due;
   } exp_t;

   logic          clk, reset, pix_valid, frame_start, res_valid, res_ready, found, overrun;
   logic [15:0]   mask;
   logic [CW-1:0] count;
   logic [XW-1:0] x_min, x_max, x_cen;
   logic [YW-1:0] y_min, y_max, y_cen;

   int unsigned cyc = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   exp_t        sb[$];

   white_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(4)) dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .frame_start(frame_start),
      .mask(mask), .res_valid(res_valid), .res_ready(res_ready), .found(found),
      .count(count), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .x_cen(x_cen), .y_cen(y_cen), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] pixel_val(input int pat, input int x, input int y);
      case (pat)
         1:       return (x == 10 && y == 5) ? 16'hFFFF : 16'h0000;
         2:       return (x >= 20 && x <= 29 && y >= 12 && y <= 21) ? 16'hFFFF : 16'h0000;
         3:       return 16'hFFDF;
         4:       return (x == 3 && y == 27) ? 16'hFFFF : 16'h0000;
         5:       return ((x + y) % 5 == 0) ? 16'hFFFF : ((x % 7 == 0) ? 16'hFFDF : 16'h7BEF);
         default: return 16'h0000;
      endcase
   endfunction

   function automatic rec_t sample();
      rec_t r;
      r.found = found;
      r.count = count;
      r.x_min = x_min;
      r.x_max = x_max;
      r.y_min = y_min;
      r.y_max = y_max;
      r.x_cen = x_cen;
      r.y_cen = y_cen;
      return r;
   endfunction

   // Drives npix pixels of a frame (frame_start on the first) and, if push is
   // set, queues the record the frame must produce.
   task automatic drive_frame(input int pat, input int npix, input bit gaps, input bit push);
      int cnt = 0, sx = 0, sy = 0, xmin = 1 << 20, xmax = -1, ymin = 1 << 20, ymax = -1;
      int unsigned end_cyc = 0;
      exp_t e;
      for (int i = 0; i < npix; i++) begin
         int x = i % H;
         int y = i / H;
         if (gaps && (i % 7 == 3)) begin
            @(posedge clk); #1;
            pix_valid = 1'b0; frame_start = 1'b0; mask = 16'hFFFF;
         end
         @(posedge clk); #1;
         pix_valid = 1'b1; frame_start = (i == 0); mask = pixel_val(pat, x, y);
         if (mask == 16'hFFFF) begin
            cnt++; sx += x; sy += y;
            if (x < xmin) xmin = x;
            if (x > xmax) xmax = x;
            if (y < ymin) ymin = y;
            if (y > ymax) ymax = y;
         end
      end
      end_cyc = cyc;
      @(posedge clk); #1;
      pix_valid = 1'b0; frame_start = 1'b0; mask = 16'h0000;
      if (push) begin
         e.rec = '0;
         if (cnt != 0) begin
            e.rec.found = (cnt >= 4);
            e.rec.count = CW'(cnt);
            e.rec.x_min = XW'(xmin);
            e.rec.x_max = XW'(xmax);
            e.rec.y_min = YW'(ymin);
            e.rec.y_max = YW'(ymax);
            e.rec.x_cen = XW'(sx / cnt);
            e.rec.y_cen = YW'(sy / cnt);
         end
         e.due = end_cyc + ((cnt != 0) ? LAT_DIV : LAT_ZERO);
         sb.push_back(e);
      end
   endtask

   task automatic wait_result(output rec_t obs, output int unsigned rise, output bit ok);
      int unsigned k = 0;
      ok = 1'b0;
      rise = 0;
      obs = 'x;
      while (!ok && k < 200) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1;
            rise = cyc;
            obs = sample();
         end
         k++;
      end
   endtask

   task automatic accept();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({res_valid, overrun, sample()} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got valid=%b ovr=%b rec=%h exp all zero", res_valid, overrun, sample());
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_single_pixel();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      drive_frame(1, H * V, 1'b0, 1'b1);
      // White pixels after frame end without frame_start must be ignored.
      repeat (5) begin
         @(posedge clk); #1;
         pix_valid = 1'b1; mask = 16'hFFFF;
      end
      @(posedge clk); #1;
      pix_valid = 1'b0; mask = 16'h0000;
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL single_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL single_latency got cycle %0d exp %0d", rise, e.due);
      end
      accept();
   endtask

   task automatic test_square();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      drive_frame(2, H * V, 1'b1, 1'b1);
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL square_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL square_latency got cycle %0d exp %0d", rise, e.due);
      end
      accept();
   endtask

   task automatic test_scatter();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      drive_frame(5, H * V, 1'b0, 1'b1);
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL scatter_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL scatter_latency got cycle %0d exp %0d", rise, e.due);
      end
      accept();
   endtask

   task automatic test_black();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      for (int p = 0; p < 2; p++) begin
         drive_frame((p == 0) ? 0 : 3, H * V, 1'b0, 1'b1);
         wait_result(obs, rise, ok);
         e = sb.pop_front();
         vectors++;
         if (!ok || obs !== e.rec) begin
            miscompares++;
            $display("FAIL black_rec[%0d] got %h (seen=%0d) exp %h", p, obs, ok, e.rec);
         end
         vectors++;
         if (rise !== e.due) begin
            miscompares++;
            $display("FAIL black_latency[%0d] got cycle %0d exp %0d", p, rise, e.due);
         end
         accept();
      end
   endtask

   task automatic test_back_to_back();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      @(negedge clk);
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL overrun_before got %b exp 0", overrun);
      end
      drive_frame(2, H * V, 1'b0, 1'b1);
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL held_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL held_latency got cycle %0d exp %0d", rise, e.due);
      end
      drive_frame(1, H * V, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      vectors++;
      if ({res_valid, overrun, sample()} !== {1'b1, 1'b1, e.rec}) begin
         miscompares++;
         $display("FAIL held_stable got valid=%b ovr=%b rec=%h exp valid=1 ovr=1 rec=%h",
                  res_valid, overrun, sample(), e.rec);
      end
      accept();
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_after_accept got %b exp 0", res_valid);
      end
      drive_frame(4, H * V, 1'b0, 1'b1);
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL third_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL third_latency got cycle %0d exp %0d", rise, e.due);
      end
      accept();
   endtask

   task automatic test_restart();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      drive_frame(2, 15 * H + 20, 1'b0, 1'b0);
      drive_frame(1, H * V, 1'b0, 1'b1);
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL restart_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL restart_latency got cycle %0d exp %0d", rise, e.due);
      end
      accept();
   endtask

   task automatic test_reset_divide();
      rec_t obs; int unsigned rise; bit ok; exp_t e;
      bit seen = 1'b0;
      drive_frame(2, H * V, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if ({res_valid, overrun, sample()} !== '0) begin
         miscompares++;
         $display("FAIL async_reset got valid=%b ovr=%b rec=%h exp all zero", res_valid, overrun, sample());
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < int'(H * V) + 60; i++) begin
         @(posedge clk); #1;
         pix_valid = (i < int'(H * V));
         frame_start = 1'b0;
         mask = 16'hFFFF;
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      pix_valid = 1'b0;
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL no_record_without_start got res_valid seen=%b exp 0", seen);
      end
      drive_frame(4, H * V, 1'b0, 1'b1);
      wait_result(obs, rise, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || obs !== e.rec) begin
         miscompares++;
         $display("FAIL post_reset_rec got %h (seen=%0d) exp %h", obs, ok, e.rec);
      end
      vectors++;
      if (rise !== e.due) begin
         miscompares++;
         $display("FAIL post_reset_latency got cycle %0d exp %0d", rise, e.due);
      end
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_overrun got %b exp 0", overrun);
      end
      accept();
   endtask

   initial begin
      reset = 1'b0;
      pix_valid = 1'b0;
      frame_start = 1'b0;
      mask = 16'h0000;
      res_ready = 1'b0;
      test_reset();
      test_single_pixel();
      test_square();
      test_scatter();
      test_black();
      test_back_to_back();
      test_restart();
      test_reset_divide();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog simulation did not complete, %0d vectors applied", vectors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/white_locator.md
# white_locator

Consumes the per-pixel RGB565 threshold mask produced by the white-detection stage and reduces each frame to one result: white-pixel count, bounding box and integer centroid. It sits after the detector in the video path. It delivers one result record per frame over a valid/ready handshake to the downstream tracking/control logic.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MIN_COUNT, 4, minimum white pixels for `found`
- X_W / Y_W, $clog2(H_ACTIVE) / $clog2(V_ACTIVE), coordinate widths (10 / 9)
- CNT_W, $clog2(H_ACTIVE*V_ACTIVE+1), count width (19)
- SUM_W, 28, centroid accumulator width

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  mask pixel present this cycle
- frame_start  in  1  qualifies the first pixel of a frame; only meaningful when pix_valid=1
- mask  in  16  RGB565 mask pixel from the detector
- res_valid  out  1  result record valid
- res_ready  in  1  downstream accepts the record
- found  out  1  count >= MIN_COUNT
- count  out  CNT_W  white pixels in the frame
- x_min, x_max  out  X_W  bounding box columns
- y_min, y_max  out  Y_W  bounding box rows
- x_cen  out  X_W  floor(sum_x / count)
- y_cen  out  Y_W  floor(sum_y / count)
- overrun  out  1  sticky: a frame result was dropped

## Operation
- White pixel: mask == 16'hFFFF, meaning all three channels are saturated. Any other value is non-white.
- Position counters x, y:
  - A pixel with frame_start sets x=0, y=0 for that pixel and clears all accumulators, discarding any partial frame.
  - On each later valid pixel, x increments; at x=H_ACTIVE-1, x wraps to 0 and y increments.
- Frame end: a valid pixel at (H_ACTIVE-1, V_ACTIVE-1). Valid pixels after frame end and before the next frame_start are ignored.
- Accumulators, updated for each in-frame white pixel:
  - count += 1
  - sum_x += x, sum_y += y
  - x_min / x_max / y_min / y_max track the extremes. Initial values are min = all-ones, max = 0.
- On the frame-end edge, the accumulators, including that final pixel, are copied to a snapshot and then cleared.
- Result FSM:
  - IDLE: on a snapshot, go to DIVIDE if count != 0, otherwise go to HOLD with all fields 0 and found=0.
  - DIVIDE: two divider instances compute sum_x/count and sum_y/count in parallel over SUM_W cycles, then go to HOLD.
  - HOLD: res_valid=1 and all fields are stable. The record transfers on res_valid&&res_ready; the FSM then returns to IDLE.
- A frame end that occurs while the FSM is in DIVIDE or HOLD does not disturb the current record. Its snapshot is discarded and overrun is set. Accumulation of the following frame proceeds normally.
- overrun clears only on reset.
- Width rules:
  - Counters are unsigned.
  - The quotients are truncated to X_W/Y_W; they are guaranteed to be in range because each centroid lies within its bounding box.
  - Bounding-box fields are 0 when count==0.

## Timing
- Reset value of all outputs is 0. Internal state on reset: FSM=IDLE, accumulators cleared, bounding-box mins at all-ones, position counters 0.
- Reset asserted mid-frame or mid-divide aborts everything. No record is produced until a new frame_start is followed by a complete frame.
- Latency, with N = the cycle of the frame-end pixel:
  - Snapshot is valid in N+1.
  - res_valid rises in N+SUM_W+2 when count != 0.
  - res_valid rises in N+2 when count == 0.
- res_valid stays high until accepted, and fields do not change while res_valid=1. res_ready has no effect when res_valid=0.
- frame_start on the same cycle as an overrun-causing frame end cannot occur: the two events are exclusive by position.
- Throughput: one pixel per clock. Accumulation never stalls.

## Structure
- Package white_locator_pkg holds:
  - the constants WHITE_PIXEL = 16'hFFFF, SUM_W
  - the FSM enum {IDLE, DIVIDE, HOLD}
  - a result struct (found, count, bounding box, centroid)
- Sub-module seq_divider: restoring unsigned divider with parameter width, start/done, SUM_W-bit dividend, CNT_W-bit divisor, one quotient bit per cycle. It is instantiated twice.

## Test plan
- Single white pixel at (100,50) in an otherwise black frame -> count=1, box 100..100 × 50..50, centroid (100,50), found=0 (below MIN_COUNT).
- 10×10 white square at x 200..209, y 300..309 -> count=100, box 200..209 × 300..309, centroid (204,304), found=1, res_valid at N+30.
- All-black frame -> res_valid at N+2, found=0, all fields 0. Pixels of value 16'hFFDF (one channel bit clear) are likewise not counted.
- res_ready held low across two complete frames -> the first record stays stable, overrun=1. After the handshake, the third frame's result is delivered.
- frame_start reasserted at (320,200) of a frame containing white pixels -> the partial frame is discarded, and the result reflects only the restarted frame.
- reset pulsed during DIVIDE -> all outputs 0 immediately (asynchronously). No res_valid appears until the next full frame completes.
